// File: rtl/truco_pkg.sv
// -----------------------------------------------------------------------------
// truco_pkg
// Shared definitions for the truco wager/scoring blocks:
//   state_t  - wager controller states
//   DIR_*    - raise-right codes driven on Dir
//   IDX_MAX  - top of the value ladder (value 12)
//   ladder() - ladder index -> hand value (1, 3, 6, 9, 12)
// -----------------------------------------------------------------------------
package truco_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_PEND   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [1:0] DIR_BOTH = 2'b00;
  localparam logic [1:0] DIR_P1   = 2'b01;
  localparam logic [1:0] DIR_P2   = 2'b10;
  localparam logic [1:0] DIR_NONE = 2'b11;

  localparam logic [2:0] IDX_MAX = 3'd4;

  // Hand value for a ladder index; indices past the top map to 0.
  function automatic logic [3:0] ladder(input logic [2:0] idx);
    case (idx)
      3'd0:    ladder = 4'd1;
      3'd1:    ladder = 4'd3;
      3'd2:    ladder = 4'd6;
      3'd3:    ladder = 4'd9;
      3'd4:    ladder = 4'd12;
      default: ladder = 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/truco_aposta.sv
// -----------------------------------------------------------------------------
// truco_aposta
// Hand-wager controller: tracks the accepted value of the current hand as
// players raise (truco/seis/nove/doze), accept, counter-raise or fold.
//
// Parameters:
//   ACK_TIMEOUT  cycles a pending raise may wait before auto-accept (0 = off)
// Ports:
//   CLK, ClrN         clock (rising edge), asynchronous active-low reset
//   NovaMao           pulse, start a new hand (highest priority)
//   FimMao            pulse, hand decided by play
//   T1/T2, A1/A2, C1/C2  raise / accept / fold requests from player 1 / 2
//   P                 accepted hand value, 0 when no hand is active
//   Prop              proposed value while a raise is pending, else 0
//   Pend              a raise is awaiting an answer
//   Dir               raise right: 00 both, 01 P1, 10 P2, 11 nobody
//   Win1, Win2        one-cycle pulse, player wins by opponent fold
//   ErrReq            one-cycle pulse, an illegal request was ignored
// All outputs are registered.
// -----------------------------------------------------------------------------
module truco_aposta
  import truco_pkg::*;
#(
  parameter logic [7:0] ACK_TIMEOUT = 8'd0
) (
  input  logic       CLK,
  input  logic       ClrN,
  input  logic       NovaMao,
  input  logic       FimMao,
  input  logic       T1,
  input  logic       T2,
  input  logic       A1,
  input  logic       A2,
  input  logic       C1,
  input  logic       C2,
  output logic [3:0] P,
  output logic [3:0] Prop,
  output logic       Pend,
  output logic [1:0] Dir,
  output logic       Win1,
  output logic       Win2,
  output logic       ErrReq
);

  state_t     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [1:0] dir_d;
  logic       raiser_q, raiser_d;   // 0 = player 1 raised, 1 = player 2 raised
  logic [7:0] wait_q, wait_d;
  logic [3:0] p_d, prop_d;
  logic       pend_d, win1_d, win2_d, err_d;

  logic       t_ok1, t_ok2;
  logic       ty, ay, cy, tr, ar, cr;
  logic       timeout_hit;
  logic [2:0] idx_inc;

  assign idx_inc = idx_q + 3'd1;

  // Raise right check in ACTIVE: ladder not exhausted and Dir lets the player.
  assign t_ok1 = (idx_q < IDX_MAX) && ((Dir == DIR_BOTH) || (Dir == DIR_P1));
  assign t_ok2 = (idx_q < IDX_MAX) && ((Dir == DIR_BOTH) || (Dir == DIR_P2));

  // Responder (y) and raiser (r) views of the request lines while pending.
  assign ty = raiser_q ? T1 : T2;
  assign ay = raiser_q ? A1 : A2;
  assign cy = raiser_q ? C1 : C2;
  assign tr = raiser_q ? T2 : T1;
  assign ar = raiser_q ? A2 : A1;
  assign cr = raiser_q ? C2 : C1;

  // Fires on the cycle the wait counter would reach ACK_TIMEOUT, so the
  // auto-accept is visible right after the ACK_TIMEOUT-th waiting cycle.
  assign timeout_hit = (ACK_TIMEOUT != 8'd0) &&
                       (({1'b0, wait_q} + 9'd1) >= {1'b0, ACK_TIMEOUT});

  // NOTE: every signal driven here gets a default first, so no path through
  // the case/if tree can leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    dir_d    = Dir;
    raiser_d = raiser_q;
    wait_d   = wait_q;
    win1_d   = 1'b0;
    win2_d   = 1'b0;
    err_d    = 1'b0;

    if (NovaMao) begin
      state_d  = S_ACTIVE;
      idx_d    = 3'd0;
      dir_d    = DIR_BOTH;
      raiser_d = 1'b0;
      wait_d   = 8'd0;
    end else begin
      case (state_q)
        S_ACTIVE: begin
          if (FimMao) begin
            state_d = S_DONE;
          end else begin
            if (T1 && t_ok1) begin
              state_d  = S_PEND;
              raiser_d = 1'b0;
              wait_d   = 8'd0;
            end else if (T2 && t_ok2) begin
              state_d  = S_PEND;
              raiser_d = 1'b1;
              wait_d   = 8'd0;
            end
            // A legal T2 shadowed by a legal T1 is dropped without error.
            err_d = (T1 && !t_ok1) || (T2 && !t_ok2) || A1 || A2 || C1 || C2;
          end
        end

        S_PEND: begin
          err_d = tr || ar || cr || FimMao;
          if (cy) begin
            state_d = S_DONE;
            win1_d  = !raiser_q;
            win2_d  = raiser_q;
          end else if (ay || timeout_hit) begin
            state_d = S_ACTIVE;
            idx_d   = idx_inc;
            if (idx_inc == IDX_MAX) dir_d = DIR_NONE;
            else                    dir_d = raiser_q ? DIR_P1 : DIR_P2;
          end else if (ty && (idx_inc < IDX_MAX)) begin
            // Counter-raise: accept the pending value and raise it again.
            idx_d    = idx_inc;
            raiser_d = !raiser_q;
            wait_d   = 8'd0;
          end else begin
            if (ty) err_d = 1'b1;
            if (wait_q != 8'hFF) wait_d = wait_q + 8'd1;
          end
        end

        default: ;  // IDLE and DONE ignore everything but NovaMao
      endcase
    end

    p_d    = (state_d == S_IDLE) ? 4'd0 : ladder(idx_d);
    prop_d = (state_d == S_PEND) ? ladder(idx_d + 3'd1) : 4'd0;
    pend_d = (state_d == S_PEND);
  end

  // NOTE: state flops use non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge CLK or negedge ClrN) begin
    if (!ClrN) begin
      state_q  <= S_IDLE;
      idx_q    <= 3'd0;
      raiser_q <= 1'b0;
      wait_q   <= 8'd0;
      P        <= 4'd0;
      Prop     <= 4'd0;
      Pend     <= 1'b0;
      Dir      <= DIR_BOTH;
      Win1     <= 1'b0;
      Win2     <= 1'b0;
      ErrReq   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      raiser_q <= raiser_d;
      wait_q   <= wait_d;
      P        <= p_d;
      Prop     <= prop_d;
      Pend     <= pend_d;
      Dir      <= dir_d;
      Win1     <= win1_d;
      Win2     <= win2_d;
      ErrReq   <= err_d;
    end
  end

endmodule

// File: tb/tb_truco_aposta.sv
// -----------------------------------------------------------------------------
// tb_truco_aposta
// Self-checking bench for truco_aposta. Each stimulus cycle pushes the
// expected outputs to a scoreboard queue; after the edge the entry is popped
// and compared against the selected instance (default or ACK_TIMEOUT = 5).
// -----------------------------------------------------------------------------
module tb_truco_aposta;

  // Request bit positions in the stimulus vector.
  localparam logic [7:0] NM  = 8'h01;
  localparam logic [7:0] FM  = 8'h02;
  localparam logic [7:0] RT1 = 8'h04;
  localparam logic [7:0] RT2 = 8'h08;
  localparam logic [7:0] RA1 = 8'h10;
  localparam logic [7:0] RA2 = 8'h20;
  localparam logic [7:0] RC1 = 8'h40;
  localparam logic [7:0] RC2 = 8'h80;

  typedef struct {
    string      tag;
    bit         use_to;
    logic [3:0] p;
    logic [3:0] prop;
    logic       pend;
    logic [1:0] dir;
    logic       w1;
    logic       w2;
    logic       err;
  } exp_t;

  logic CLK = 1'b0;
  logic ClrN;
  logic NovaMao, FimMao, T1, T2, A1, A2, C1, C2;

  logic [3:0] P, Prop, P_to, Prop_to;
  logic [1:0] Dir, Dir_to;
  logic       Pend, Win1, Win2, ErrReq;
  logic       Pend_to, Win1_to, Win2_to, ErrReq_to;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 CLK = ~CLK;

  truco_aposta dut (
    .CLK(CLK), .ClrN(ClrN), .NovaMao(NovaMao), .FimMao(FimMao),
    .T1(T1), .T2(T2), .A1(A1), .A2(A2), .C1(C1), .C2(C2),
    .P(P), .Prop(Prop), .Pend(Pend), .Dir(Dir),
    .Win1(Win1), .Win2(Win2), .ErrReq(ErrReq)
  );

  truco_aposta #(.ACK_TIMEOUT(8'd5)) dut_to (
    .CLK(CLK), .ClrN(ClrN), .NovaMao(NovaMao), .FimMao(FimMao),
    .T1(T1), .T2(T2), .A1(A1), .A2(A2), .C1(C1), .C2(C2),
    .P(P_to), .Prop(Prop_to), .Pend(Pend_to), .Dir(Dir_to),
    .Win1(Win1_to), .Win2(Win2_to), .ErrReq(ErrReq_to)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic apply(input logic [7:0] in);
    {C2, C1, A2, A1, T2, T1, FimMao, NovaMao} = in;
  endtask

  // One stimulus cycle: drive, push expectation, clock, pop and compare.
  task automatic cyc(input logic [7:0] in, input string tag, input bit use_to,
                     input logic [3:0] p, input logic [3:0] prop, input logic pend,
                     input logic [1:0] dir, input logic w1, input logic w2,
                     input logic err);
    exp_t e;
    apply(in);
    sb.push_back('{tag, use_to, p, prop, pend, dir, w1, w2, err});
    @(posedge CLK);
    #1;
    apply(8'h00);
    e = sb.pop_front();
    if (e.use_to) begin
      check({e.tag, ".P"},      P_to,      e.p);
      check({e.tag, ".Prop"},   Prop_to,   e.prop);
      check({e.tag, ".Pend"},   Pend_to,   e.pend);
      check({e.tag, ".Dir"},    Dir_to,    e.dir);
      check({e.tag, ".Win1"},   Win1_to,   e.w1);
      check({e.tag, ".Win2"},   Win2_to,   e.w2);
      check({e.tag, ".ErrReq"}, ErrReq_to, e.err);
    end else begin
      check({e.tag, ".P"},      P,      e.p);
      check({e.tag, ".Prop"},   Prop,   e.prop);
      check({e.tag, ".Pend"},   Pend,   e.pend);
      check({e.tag, ".Dir"},    Dir,    e.dir);
      check({e.tag, ".Win1"},   Win1,   e.w1);
      check({e.tag, ".Win2"},   Win2,   e.w2);
      check({e.tag, ".ErrReq"}, ErrReq, e.err);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".P"},      P,      4'd0);
    check({tag, ".Prop"},   Prop,   4'd0);
    check({tag, ".Pend"},   Pend,   1'b0);
    check({tag, ".Dir"},    Dir,    2'b00);
    check({tag, ".Win"},    {Win1, Win2}, 2'b00);
    check({tag, ".ErrReq"}, ErrReq, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ClrN = 1'b0;
    apply(8'h00);
    repeat (2) @(posedge CLK);
    #1;
    check_all_zero("reset");
    ClrN = 1'b1;
    cyc(8'h00, "idle", 0, 4'd0, 4'd0, 0, 2'b00, 0, 0, 0);

    // Truco accepted, then the raiser may not raise again.
    cyc(NM,   "t1.new",  0, 4'd1, 4'd0, 0, 2'b00, 0, 0, 0);
    cyc(RT1,  "t1.t1",   0, 4'd1, 4'd3, 1, 2'b00, 0, 0, 0);
    cyc(RA2,  "t1.a2",   0, 4'd3, 4'd0, 0, 2'b10, 0, 0, 0);
    cyc(RT1,  "t1.bad",  0, 4'd3, 4'd0, 0, 2'b10, 0, 0, 1);
    cyc(8'h0, "t1.hold", 0, 4'd3, 4'd0, 0, 2'b10, 0, 0, 0);
    cyc(RA1,  "t1.aact", 0, 4'd3, 4'd0, 0, 2'b10, 0, 0, 1);

    // Counter-raises up the ladder to 12.
    cyc(NM,   "t2.new", 0, 4'd1,  4'd0,  0, 2'b00, 0, 0, 0);
    cyc(RT1,  "t2.t1",  0, 4'd1,  4'd3,  1, 2'b00, 0, 0, 0);
    cyc(RT2,  "t2.t2",  0, 4'd3,  4'd6,  1, 2'b00, 0, 0, 0);
    cyc(RT1,  "t2.t1b", 0, 4'd6,  4'd9,  1, 2'b00, 0, 0, 0);
    cyc(RA2,  "t2.a2",  0, 4'd9,  4'd0,  0, 2'b10, 0, 0, 0);
    cyc(RT2,  "t2.t2b", 0, 4'd9,  4'd12, 1, 2'b10, 0, 0, 0);
    cyc(RA1,  "t2.a1",  0, 4'd12, 4'd0,  0, 2'b11, 0, 0, 0);
    cyc(RT2,  "t2.top", 0, 4'd12, 4'd0,  0, 2'b11, 0, 0, 1);

    // Counter-raise refused when it would go past 12.
    cyc(NM,   "t2b.new", 0, 4'd1,  4'd0,  0, 2'b00, 0, 0, 0);
    cyc(RT1,  "t2b.r1",  0, 4'd1,  4'd3,  1, 2'b00, 0, 0, 0);
    cyc(RT2,  "t2b.r2",  0, 4'd3,  4'd6,  1, 2'b00, 0, 0, 0);
    cyc(RT1,  "t2b.r3",  0, 4'd6,  4'd9,  1, 2'b00, 0, 0, 0);
    cyc(RT2,  "t2b.r4",  0, 4'd9,  4'd12, 1, 2'b00, 0, 0, 0);
    cyc(RT1,  "t2b.r5",  0, 4'd9,  4'd12, 1, 2'b00, 0, 0, 1);
    cyc(RA1,  "t2b.acc", 0, 4'd12, 4'd0,  0, 2'b11, 0, 0, 0);

    // Fold on a re-raise: pre-raise value kept, DONE ignores requests.
    cyc(NM,   "t3.new",  0, 4'd1, 4'd0, 0, 2'b00, 0, 0, 0);
    cyc(RT2,  "t3.t2",   0, 4'd1, 4'd3, 1, 2'b00, 0, 0, 0);
    cyc(RA1,  "t3.a1",   0, 4'd3, 4'd0, 0, 2'b01, 0, 0, 0);
    cyc(RT1,  "t3.t1",   0, 4'd3, 4'd6, 1, 2'b01, 0, 0, 0);
    cyc(RA1,  "t3.self", 0, 4'd3, 4'd6, 1, 2'b01, 0, 0, 1);
    cyc(RC2,  "t3.c2",   0, 4'd3, 4'd0, 0, 2'b01, 1, 0, 0);
    cyc(8'h0, "t3.pls",  0, 4'd3, 4'd0, 0, 2'b01, 0, 0, 0);
    cyc(RT1,  "t3.done", 0, 4'd3, 4'd0, 0, 2'b01, 0, 0, 0);
    cyc(FM | RA1, "t3.dn2", 0, 4'd3, 4'd0, 0, 2'b01, 0, 0, 0);

    // Simultaneous raises and simultaneous fold/accept.
    cyc(NM,        "t4.new",  0, 4'd1, 4'd0, 0, 2'b00, 0, 0, 0);
    cyc(RT1 | RT2, "t4.both", 0, 4'd1, 4'd3, 1, 2'b00, 0, 0, 0);
    cyc(RC2 | RA2, "t4.c2a2", 0, 4'd1, 4'd0, 0, 2'b00, 1, 0, 0);

    // Player 1 folds on player 2's truco.
    cyc(NM,   "w2.new", 0, 4'd1, 4'd0, 0, 2'b00, 0, 0, 0);
    cyc(RT2,  "w2.t2",  0, 4'd1, 4'd3, 1, 2'b00, 0, 0, 0);
    cyc(RC1,  "w2.c1",  0, 4'd1, 4'd0, 0, 2'b00, 0, 1, 0);

    // FimMao: ends an active hand, rejected while pending.
    cyc(NM,   "fm.new",  0, 4'd1, 4'd0, 0, 2'b00, 0, 0, 0);
    cyc(RT1,  "fm.t1",   0, 4'd1, 4'd3, 1, 2'b00, 0, 0, 0);
    cyc(FM,   "fm.pend", 0, 4'd1, 4'd3, 1, 2'b00, 0, 0, 1);
    cyc(RA2,  "fm.a2",   0, 4'd3, 4'd0, 0, 2'b10, 0, 0, 0);
    cyc(FM,   "fm.act",  0, 4'd3, 4'd0, 0, 2'b10, 0, 0, 0);
    cyc(RT2,  "fm.done", 0, 4'd3, 4'd0, 0, 2'b10, 0, 0, 0);

    // Auto-accept after 5 waiting cycles on the ACK_TIMEOUT = 5 instance.
    cyc(NM,   "to.new", 1, 4'd1, 4'd0, 0, 2'b00, 0, 0, 0);
    cyc(RT1,  "to.t1",  1, 4'd1, 4'd3, 1, 2'b00, 0, 0, 0);
    for (int i = 0; i < 4; i++)
      cyc(8'h0, "to.wait", 1, 4'd1, 4'd3, 1, 2'b00, 0, 0, 0);
    cyc(8'h0, "to.fire", 1, 4'd3, 4'd0, 0, 2'b10, 0, 0, 0);
    cyc(8'h0, "to.off",  0, 4'd1, 4'd3, 1, 2'b00, 0, 0, 0);

    // Asynchronous reset mid-pending, then restart and NovaMao while pending.
    cyc(NM,   "rs.new", 0, 4'd1, 4'd0, 0, 2'b00, 0, 0, 0);
    cyc(RT1,  "rs.t1",  0, 4'd1, 4'd3, 1, 2'b00, 0, 0, 0);
    ClrN = 1'b0;
    #2;
    check_all_zero("rs.async");
    ClrN = 1'b1;
    cyc(RT1,  "rs.idle", 0, 4'd0, 4'd0, 0, 2'b00, 0, 0, 0);
    cyc(NM,   "nm.new",  0, 4'd1, 4'd0, 0, 2'b00, 0, 0, 0);
    cyc(RT1,  "nm.t1",   0, 4'd1, 4'd3, 1, 2'b00, 0, 0, 0);
    cyc(NM | RA2, "nm.pend", 0, 4'd1, 4'd0, 0, 2'b00, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/truco_aposta.md
# truco_aposta

Hand-wager controller for the truco scoring datapath. Tracks the value of the current hand (1, 3, 6, 9, 12) as players call truco, accept, counter-raise, or fold. Sits directly upstream of the match-scoring top: its `P` output drives that block's hand-point input, and its fold-win pulses merge into the `v1`/`v2` vaza-win lines.

## Interface
Parameters:
- `ACK_TIMEOUT`, default 0: cycles a pending raise may wait before it is auto-accepted. 0 disables the timeout. Width is 8 bits.

Ports:
- `CLK` in 1: system clock, rising edge.
- `ClrN` in 1: asynchronous, active-low reset.
- `NovaMao` in 1: pulse that starts a new hand.
- `FimMao` in 1: pulse from vaza logic; the hand was decided by play.
- `T1`, `T2` in 1: raise request (truco / seis / nove / doze) from player 1 / player 2.
- `A1`, `A2` in 1: accept the pending raise.
- `C1`, `C2` in 1: run (fold) on the pending raise.
- `P` out 4: accepted hand value; 0 when no hand is active.
- `Prop` out 4: proposed value while a raise is pending, else 0.
- `Pend` out 1: a raise is awaiting an answer.
- `Dir` out 2: raise right. 00 = both, 01 = P1 only, 10 = P2 only, 11 = nobody (value is 12).
- `Win1`, `Win2` out 1: one-cycle pulse, player wins the hand by opponent fold.
- `ErrReq` out 1: one-cycle pulse, an illegal request was ignored.

## Operation
- Value ladder, index 0..4 → 1, 3, 6, 9, 12.
- States: IDLE, ACTIVE, PEND, DONE.
- **IDLE:** `P` = 0. `NovaMao` → ACTIVE, idx = 0, `Dir` = 00.
- **ACTIVE:** Tx is legal if idx < 4 and `Dir` permits x.
  - Legal Tx → PEND; raiser = x; `Prop` = ladder[idx+1].
  - Illegal Tx → `ErrReq`, no state change.
  - T1 and T2 in the same cycle with both legal: P1 wins, T2 is dropped silently.
  - Ax and Cx in ACTIVE → `ErrReq`.
  - `FimMao` → DONE.
- **PEND** (responder y = opponent of the raiser):
  - Priority is Cy > Ay > Ty.
  - Cy → pulse Win(raiser), `P` holds the pre-raise value, → DONE.
  - Ay → idx += 1; `Dir` = y (11 if idx becomes 4); → ACTIVE.
  - Ty when idx+1 < 4: implicit accept, idx += 1; new raiser = y; `Prop` = ladder[idx+1]; stay in PEND.
  - Ty when idx+1 = 4 → `ErrReq`.
  - Any input from the raiser → `ErrReq`, ignored.
  - `FimMao` while pending → `ErrReq`, ignored.
  - Timeout: if `ACK_TIMEOUT` ≠ 0 and the wait counter reaches `ACK_TIMEOUT`, treat as Ay.
- **DONE:** `P` holds; all requests are ignored with no `ErrReq`. `NovaMao` → ACTIVE.
- `NovaMao` has top priority in every state: restart to ACTIVE, idx = 0, pending cleared, wait counter cleared.
- `Dir` = 11 whenever idx = 4.

## Timing
- All outputs are registered. An input sampled at edge k takes effect on the outputs after edge k, so latency is 1 cycle.
- `Win1`, `Win2`, `ErrReq` are high for exactly one cycle.
- Reset values: state IDLE; `P` = 0; `Prop` = 0; `Pend` = 0; `Dir` = 00; `Win1` = `Win2` = `ErrReq` = 0; idx = 0; wait counter = 0.
- Reset asserted mid-hand clears everything immediately, asynchronously. The first edge after deassertion sees IDLE.
- Wait counter: cleared on entry to PEND and on each counter-raise. It increments each cycle in PEND and saturates at 255.

## Structure
- Package `truco_pkg` holds:
  - state enum;
  - `Dir` codes;
  - ladder constant/function mapping idx → value;
  - `IDX_MAX` = 4.
- Sharing the package keeps the ladder consistent with the scoring blocks.
- Single module, no sub-module. The ladder lookup is a package function.

## Test plan
- Reset, `NovaMao`, T1, A2 → `P` = 3, `Dir` = 10, `Pend` = 0. T1 again → `ErrReq` = 1, `P` stays 3.
- `NovaMao`, T1, T2, T1, A2 → `P` = 9, then `Dir` = 10. T2, A1 → `P` = 12, `Dir` = 11. T2 → `ErrReq`.
- `NovaMao`, T2, A1, T1, C2 → `Win1` pulse for 1 cycle, `P` = 3 (the 6 was not accepted), state DONE. Later T1 → no `ErrReq`.
- `NovaMao`, T1 and T2 same cycle → raiser = P1, `Prop` = 3. C2 and A2 same cycle → `Win1`, `P` = 1.
- `ACK_TIMEOUT` = 5: `NovaMao`, T1, idle 5 cycles → `P` = 3, `Dir` = 10 after the 5th cycle.
- `NovaMao`, T1, then `ClrN` low mid-PEND → all outputs 0 with no clock edge needed. `NovaMao` during PEND → `P` = 1, `Pend` = 0.
